// File: rtl/conv_vram_pkg.sv
// Shared types and constants for the 5x5 VRAM convolution engine.
// Holds the FSM state encoding, the separable kernel weights and memory map constants.
// Pure declarations; no logic.
package conv_vram_pkg;

  localparam int          ADDR_W    = 16;
  localparam logic [15:0] OUT_BASE  = 16'h8000;
  localparam logic [15:0] MAX_N     = 16'd181;
  localparam int          WIN_BYTES = 25;
  localparam int          WIN_W     = 8 * WIN_BYTES;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE
  } state_t;

  // 1-D binomial weights; the 2-D kernel is the outer product w[r]*w[c], summing to 256.
  localparam logic [4:0][7:0] KW = {8'd1, 8'd4, 8'd6, 8'd4, 8'd1};

endpackage

// File: rtl/conv_vram_mem.sv
// 64 KiB byte-wide VRAM: one write port, a 4-byte CPU read port and a 5x5 strided window read port.
// Latency: CPU read data and window data are both registered, valid 1 cycle after address.
// Backpressure: none; every port completes in a fixed cycle, write port muxing is done by the caller.
module conv_vram_mem
  import conv_vram_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [15:0]       i_waddr,
  input  logic [7:0]        i_wdata,
  input  logic [15:0]       i_raddr,
  output logic [31:0]       o_rdata,
  input  logic              i_win_en,
  input  logic [15:0]       i_daddr,
  input  logic [15:0]       i_n,
  output logic [WIN_W-1:0]  o_win
);

  logic [7:0]       r_mem [0:(1<<ADDR_W)-1];
  logic [31:0]      r_rdata;
  logic [WIN_W-1:0] r_win;
  logic [15:0]      w_a1;
  logic [15:0]      w_a2;
  logic [15:0]      w_a3;

  // Upper CPU read bytes wrap around the 16-bit address space.
  assign w_a1 = i_raddr + 16'd1;
  assign w_a2 = i_raddr + 16'd2;
  assign w_a3 = i_raddr + 16'd3;

  // Single byte write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered little-endian 32-bit CPU read.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= {r_mem[w_a3], r_mem[w_a2], r_mem[w_a1], r_mem[i_raddr]};
    end
  end

  // Capture the 5x5 window rooted at i_daddr, row stride i_n; byte k = r*5+c.
  always_ff @(posedge i_clk) begin
    if (i_win_en) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 5; c++) begin
          r_win[8*(r*5+c) +: 8] <= r_mem[i_daddr + 16'(r) * i_n + 16'(c)];
        end
      end
    end
  end

  assign o_rdata = r_rdata;
  assign o_win   = r_win;

endmodule

// File: rtl/conv_vram_accel.sv
// Memory-mapped 5x5 binomial convolution engine over a private VRAM, producing an (N-4)^2 valid output.
// Latency: 3 cycles per output pixel (FETCH/WAIT/WRITE); busy 3*(N-4)^2 cycles; CPU read data 1 cycle.
// Backpressure: CPU writes are dropped while busy; enable edges during a run are ignored, not queued.
module conv_vram_accel
  import conv_vram_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_waddr,
  input  logic [7:0]  i_cpu_wdata,
  input  logic [15:0] i_cpu_raddr,
  output logic [31:0] o_cpu_rdata,
  input  logic [15:0] i_image_size,
  input  logic        i_enable,
  output logic        o_ready
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_x;
  logic [15:0]      r_y;
  logic [15:0]      r_n;
  logic [15:0]      w_x_nxt;
  logic [15:0]      w_y_nxt;
  logic [15:0]      w_n_nxt;
  logic             r_enable_q;
  logic             w_start;
  logic             w_size_ok;
  logic             w_ready;
  logic             w_win_en;
  logic             w_dwe;
  logic [15:0]      w_daddr;
  logic [15:0]      w_oaddr;
  logic [15:0]      w_last;
  logic [WIN_W-1:0] w_win;
  logic [15:0]      w_acc;
  logic [7:0]       w_result;
  logic             w_mem_we;
  logic [15:0]      w_mem_waddr;
  logic [7:0]       w_mem_wdata;

  assign w_ready   = (r_state == IDLE);
  assign w_size_ok = (i_image_size >= 16'd5) && (i_image_size <= MAX_N);
  assign w_start   = i_enable & ~r_enable_q & w_size_ok;
  assign w_last    = r_n - 16'd5;
  assign w_daddr   = r_y * r_n + r_x;
  assign w_oaddr   = OUT_BASE + r_y * (r_n - 16'd4) + r_x;

  // Enable edge detector, state register and pixel counters.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_n        <= '0;
      r_enable_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_n        <= w_n_nxt;
      r_enable_q <= i_enable;
    end
  end

  // Next-state, counter advance and datapath strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_n_nxt     = r_n;
    w_win_en    = 1'b0;
    w_dwe       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_n_nxt     = i_image_size;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        w_win_en    = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        w_state_nxt = WRITE;
      end
      WRITE: begin
        w_dwe = 1'b1;
        if (r_x == w_last) begin
          w_x_nxt = '0;
          if (r_y == w_last) begin
            w_state_nxt = IDLE;
          end else begin
            w_y_nxt     = r_y + 16'd1;
            w_state_nxt = FETCH;
          end
        end else begin
          w_x_nxt     = r_x + 16'd1;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Multiply-accumulate over the captured window; the sum never exceeds 16 bits.
  always_comb begin
    w_acc = '0;
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 5; c++) begin
        w_acc = w_acc + 16'(KW[r]) * 16'(KW[c]) * 16'(w_win[8*(r*5+c) +: 8]);
      end
    end
    w_result = 8'(w_acc >> 8);
  end

  // Engine owns the write port while busy; CPU writes only land when idle.
  always_comb begin
    w_mem_we    = w_dwe | (i_cpu_we & w_ready);
    w_mem_waddr = w_dwe ? w_oaddr  : i_cpu_waddr;
    w_mem_wdata = w_dwe ? w_result : i_cpu_wdata;
  end

  conv_vram_mem u_mem (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_we     (w_mem_we),
    .i_waddr  (w_mem_waddr),
    .i_wdata  (w_mem_wdata),
    .i_raddr  (i_cpu_raddr),
    .o_rdata  (o_cpu_rdata),
    .i_win_en (w_win_en),
    .i_daddr  (w_daddr),
    .i_n      (r_n),
    .o_win    (w_win)
  );

  assign o_ready = w_ready;

endmodule

// File: tb/tb_conv_vram_accel.sv
// Directed bench for conv_vram_accel: CPU reads are scoreboarded, control timing checked inline.
// Latency: reads compared one cycle after issue by an independent negedge monitor.
// Backpressure: n/a; all waits on the DUT are cycle-bounded.
module tb_conv_vram_accel;

  logic        clk;
  logic        rst;
  logic        cpu_we;
  logic [15:0] cpu_waddr;
  logic [7:0]  cpu_wdata;
  logic [15:0] cpu_raddr;
  logic [31:0] cpu_rdata;
  logic [15:0] image_size;
  logic        enable;
  logic        ready;

  typedef struct {
    string       nm;
    logic [31:0] exp;
    logic [31:0] mask;
  } rd_exp_t;

  rd_exp_t sb[$];
  logic    rd_req;
  logic    rd_vld_q;
  int      n_checks;
  int      n_pass;

  conv_vram_accel dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cpu_we     (cpu_we),
    .i_cpu_waddr  (cpu_waddr),
    .i_cpu_wdata  (cpu_wdata),
    .i_cpu_raddr  (cpu_raddr),
    .o_cpu_rdata  (cpu_rdata),
    .i_image_size (image_size),
    .i_enable     (enable),
    .o_ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  // Read data is valid the cycle after a read request was sampled.
  always @(posedge clk) rd_vld_q <= rd_req;

  // Monitor: pop one expectation per valid read and compare under its mask.
  always @(negedge clk) begin
    if (rd_vld_q) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_read", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        chk(e.nm, cpu_rdata & e.mask, e.exp & e.mask);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_we    = 1'b1;
    cpu_waddr = a;
    cpu_wdata = d;
    tick(1);
    cpu_we    = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [31:0] exp, input logic [31:0] mask);
    rd_exp_t e;
    e.nm = nm; e.exp = exp; e.mask = mask;
    sb.push_back(e);
    cpu_raddr = a;
    rd_req    = 1'b1;
    tick(1);
    rd_req    = 1'b0;
  endtask

  // Called one step after the start edge; counts cycles until ready returns.
  task automatic measure_busy(input string nm, input int exp);
    int cnt;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 5000) begin
      tick(1);
      cnt++;
    end
    chk(nm, 32'(cnt), 32'(exp));
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      tick(1);
      if (ready !== 1'b1) lows++;
    end
  endtask

  int lows;

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b1; cpu_we = 1'b0; cpu_waddr = '0; cpu_wdata = '0;
    cpu_raddr = '0; image_size = '0; enable = 1'b0; rd_req = 1'b0;
    tick(3);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_rdata", cpu_rdata, 32'd0);
    rst = 1'b0;
    tick(1);

    // Little-endian 4-byte read and address wrap.
    wr(16'h0010, 8'h11); wr(16'h0011, 8'h22); wr(16'h0012, 8'h33); wr(16'h0013, 8'h44);
    rd("rd_word", 16'h0010, 32'h44332211, 32'hFFFF_FFFF);
    wr(16'hFFFE, 8'hAA); wr(16'hFFFF, 8'hBB); wr(16'h0000, 8'hCC); wr(16'h0001, 8'hDD);
    rd("rd_wrap", 16'hFFFE, 32'hDDCCBBAA, 32'hFFFF_FFFF);

    // N=5 flat image: one output pixel equal to the input level, 3 busy cycles.
    for (int i = 0; i < 25; i++) wr(16'(i), 8'd100);
    image_size = 16'd5;
    enable = 1'b1;
    tick(1);
    measure_busy("busy_n5", 3);
    rd("out_n5", 16'h8000, 32'd100, 32'h0000_00FF);
    // Enable stays high: no second run may start and clobber the marker.
    wr(16'h8000, 8'h55);
    count_low(20, lows);
    chk("hold_enable_no_rerun", 32'(lows), 32'd0);
    rd("hold_enable_marker", 16'h8000, 32'h55, 32'h0000_00FF);
    enable = 1'b0;
    tick(1);

    // N=6 impulse at (2,2): out = 255*K >> 8 with K = 36,24,24,16.
    for (int i = 0; i < 36; i++) wr(16'(i), (i == 14) ? 8'd255 : 8'd0);
    image_size = 16'd6;
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    measure_busy("busy_n6", 12);
    rd("out_n6", 16'h8000, 32'h0F171723, 32'hFFFF_FFFF);

    // Out-of-range sizes are ignored.
    image_size = 16'd4;
    enable = 1'b1;
    count_low(10, lows);
    chk("size4_ignored", 32'(lows), 32'd0);
    enable = 1'b0;
    tick(1);
    image_size = 16'd200;
    enable = 1'b1;
    count_low(10, lows);
    chk("size200_ignored", 32'(lows), 32'd0);
    enable = 1'b0;
    tick(1);
    rd("out_unchanged", 16'h8000, 32'h0F171723, 32'hFFFF_FFFF);

    // N=10 ramp pix(i,j)=10i+j: row-0 outputs are the window centres 22+x.
    for (int i = 0; i < 100; i++) wr(16'(i), 8'(i));
    for (int i = 0; i < 8; i++) wr(16'h8000 + 16'(i), 8'hA5);
    image_size = 16'd10;
    enable = 1'b1;
    tick(1);
    enable = 1'b0;
    wr(16'h0003, 8'hEE);
    wr(16'h8007, 8'h00);
    tick(14);
    chk("busy_before_reset", 32'(ready), 32'd0);
    rst = 1'b1;
    tick(1);
    chk("ready_after_reset", 32'(ready), 32'd1);
    rst = 1'b0;
    tick(5);
    rd("rst_out_0_3", 16'h8000, 32'h19181716, 32'hFFFF_FFFF);
    rd("rst_out_4_7", 16'h8004, 32'hA5A5A51A, 32'hFFFF_FFFF);
    rd("busy_write_dropped", 16'h0000, 32'h03020100, 32'hFFFF_FFFF);

    tick(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
